// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the MiniMicro multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NREGS  = 8;
  localparam int unsigned DEF_NPORTS = 2;

  // Port index as seen by decode/issue (up to four ports).
  typedef logic [1:0] port_idx_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Distance of port idx from the rotating pointer; smaller means higher priority.
  function automatic int unsigned prio_dist(input int unsigned idx,
                                            input int unsigned ptr,
                                            input int unsigned n);
    return (idx + n - (ptr % n)) % n;
  endfunction

endpackage

// File: rtl/regfile_mp_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NPORTS = DEF_NPORTS,
  parameter int unsigned PW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NPORTS-1:0] gnt
);

  // A requester is granted when no other requester sits closer to the pointer.
  always_comb begin
    gnt = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      gnt[p] = req[p];
      for (int unsigned q = 0; q < NPORTS; q++) begin
        if (q != p && req[q] &&
            prio_dist(q, int'(ptr), NPORTS) < prio_dist(p, int'(ptr), NPORTS))
          gnt[p] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with round-robin write-collision resolution,
// optional write-to-read bypass, optional hardwired r0 and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned NPORTS  = DEF_NPORTS,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0,
  localparam int unsigned AW     = clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS*AW-1:0]     as,
  input  logic [NPORTS*AW-1:0]     bs,
  input  logic [NPORTS*AW-1:0]     cs,
  input  logic [NPORTS-1:0]        cw,
  input  logic [NPORTS*DATA_W-1:0] cd,
  input  logic [NPORTS-1:0]        rsv,
  output logic [NPORTS*DATA_W-1:0] ad,
  output logic [NPORTS*DATA_W-1:0] bd,
  output logic [NPORTS*DATA_W-1:0] cdo,
  output logic [NPORTS-1:0]        wt,
  output logic [NREGS-1:0]         busy
);

  localparam int unsigned RRW = (NPORTS > 1) ? clog2(NPORTS) : 1;

  logic [AW-1:0]     asel [NPORTS];
  logic [AW-1:0]     bsel [NPORTS];
  logic [AW-1:0]     csel [NPORTS];
  logic [DATA_W-1:0] wdat [NPORTS];

  logic [NPORTS-1:0] wv, coll, lose, win, cwin, ptr_gnt;
  logic [RRW-1:0]    rr_q, rr_d;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [DATA_W-1:0] cdat  [NREGS];
  logic [DATA_W-1:0] rview [NREGS];
  logic [NREGS-1:0]  cen, rset, busy_q, busy_d;

  // Split the packed per-port buses into per-port fields.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      asel[p] = as[p*AW +: AW];
      bsel[p] = bs[p*AW +: AW];
      csel[p] = cs[p*AW +: AW];
      wdat[p] = cd[p*DATA_W +: DATA_W];
    end
  end

  // Pairwise collision check: a port loses to any same-target port nearer to rr.
  always_comb begin
    wv   = '0;
    coll = '0;
    lose = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      wv[p] = cw[p] && !rst && !(ZERO_R0 && (csel[p] == '0));
    end
    for (int unsigned p = 0; p < NPORTS; p++) begin
      for (int unsigned q = 0; q < NPORTS; q++) begin
        if (q != p && wv[p] && wv[q] && csel[q] == csel[p]) begin
          coll[p] = 1'b1;
          if (prio_dist(q, int'(rr_q), NPORTS) < prio_dist(p, int'(rr_q), NPORTS))
            lose[p] = 1'b1;
        end
      end
    end
    win  = wv & ~lose;
    cwin = coll & ~lose;
  end

  // Fixed pointer of zero picks the lowest-index collision winner.
  rr_arbiter #(
    .NPORTS (NPORTS),
    .PW     (RRW)
  ) u_ptr_arb (
    .req (cwin),
    .ptr ('0),
    .gnt (ptr_gnt)
  );

  // Advance rr past the lowest-index collision winner; hold when nothing collided.
  always_comb begin
    rr_d = rr_q;
    if (|lose) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (ptr_gnt[p]) rr_d = RRW'((p + 1) % NPORTS);
      end
    end
  end

  // Per-register commit enable and data from the (unique) winning port.
  always_comb begin
    cen = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cdat[r] = '0;
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (win[p] && csel[p] == AW'(r)) begin
          cen[r]  = 1'b1;
          cdat[r] = wdat[p];
        end
      end
      mem_d[r] = cen[r] ? cdat[r] : mem_q[r];
    end
  end

  // Scoreboard: a new reservation overrides a same-cycle write-back clear.
  always_comb begin
    rset = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (rsv[p] && csel[p] == AW'(r) && !(ZERO_R0 && r == 0)) rset[r] = 1'b1;
      end
    end
    busy_d = rset | (busy_q & ~cen);
  end

  // Read view of every register, including bypass and hardwired r0.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (ZERO_R0 && r == 0)     rview[r] = '0;
      else if (BYPASS && cen[r]) rview[r] = cdat[r];
      else                       rview[r] = mem_q[r];
    end
  end

  // Drive the packed read buses and status outputs.
  always_comb begin
    ad  = '0;
    bd  = '0;
    cdo = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      ad [p*DATA_W +: DATA_W] = rview[asel[p]];
      bd [p*DATA_W +: DATA_W] = rview[bsel[p]];
      cdo[p*DATA_W +: DATA_W] = rview[csel[p]];
    end
    wt   = lose;
    busy = busy_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
      rr_q   <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
      busy_q <= busy_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: three instances share stimulus
// (bypass, bypass with hardwired r0, no bypass).
module tb_regfile_mp;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP*AW-1:0] as_s = '0, bs_s = '0, cs_s = '0;
  logic [NP-1:0]    cw = '0, rsv = '0;
  logic [NP*DW-1:0] cd = '0;

  logic [NP*DW-1:0] ad_a, bd_a, cdo_a, ad_z, bd_z, cdo_z, ad_n, bd_n, cdo_n;
  logic [NP-1:0]    wt_a, wt_z, wt_n;
  logic [NR-1:0]    busy_a, busy_z, busy_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NPORTS(NP), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut (
    .clk(clk), .rst(rst), .as(as_s), .bs(bs_s), .cs(cs_s), .cw(cw), .cd(cd), .rsv(rsv),
    .ad(ad_a), .bd(bd_a), .cdo(cdo_a), .wt(wt_a), .busy(busy_a));

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NPORTS(NP), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_z (
    .clk(clk), .rst(rst), .as(as_s), .bs(bs_s), .cs(cs_s), .cw(cw), .cd(cd), .rsv(rsv),
    .ad(ad_z), .bd(bd_z), .cdo(cdo_z), .wt(wt_z), .busy(busy_z));

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NPORTS(NP), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_nb (
    .clk(clk), .rst(rst), .as(as_s), .bs(bs_s), .cs(cs_s), .cw(cw), .cd(cd), .rsv(rsv),
    .ad(ad_n), .bd(bd_n), .cdo(cdo_n), .wt(wt_n), .busy(busy_n));

  task automatic idle();
    cw  = '0;
    rsv = '0;
    cd  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned p, input logic [AW-1:0] r, input logic [DW-1:0] d);
    cs_s[p*AW +: AW] = r;
    cd[p*DW +: DW]   = d;
    cw[p]            = 1'b1;
  endtask

  task automatic test_reset();
    // Colliding writes while in reset must be ignored and raise no wait.
    idle();
    wr(0, 3'd4, 16'h1111);
    wr(1, 3'd4, 16'h2222);
    as_s = {3'd4, 3'd4};
    #1;
    tests++; if (wt_a !== 2'b00) begin fails++; $display("FAIL rst_wt got %b exp 00", wt_a); end
    tests++; if (ad_a !== 32'h0) begin fails++; $display("FAIL rst_ad got %h exp 0", ad_a); end
    tests++; if (busy_a !== 8'h00) begin fails++; $display("FAIL rst_busy got %h exp 00", busy_a); end
    idle();
    rst = 1'b0;
    wr(0, 3'd3, 16'h1234);
    cs_s[5:3] = 3'd5;
    rsv[1]    = 1'b1;
    step();
    idle();
    as_s[2:0] = 3'd3;
    #1;
    tests++; if (ad_n[15:0] !== 16'h1234) begin fails++; $display("FAIL pre_rst_r3 got %h exp 1234", ad_n[15:0]); end
    tests++; if (busy_a !== 8'h20) begin fails++; $display("FAIL pre_rst_busy got %h exp 20", busy_a); end
    // Mid-run asynchronous reset.
    rst = 1'b1;
    wr(0, 3'd4, 16'h3333);
    wr(1, 3'd4, 16'h4444);
    as_s[2:0] = 3'd3;
    #1;
    tests++; if (ad_a[15:0] !== 16'h0) begin fails++; $display("FAIL mid_rst_ad got %h exp 0", ad_a[15:0]); end
    tests++; if (ad_n[15:0] !== 16'h0) begin fails++; $display("FAIL mid_rst_ad_nb got %h exp 0", ad_n[15:0]); end
    tests++; if (busy_a !== 8'h00) begin fails++; $display("FAIL mid_rst_busy got %h exp 00", busy_a); end
    tests++; if (wt_a !== 2'b00) begin fails++; $display("FAIL mid_rst_wt got %b exp 00", wt_a); end
    idle();
    rst = 1'b0;
    wr(0, 3'd3, 16'h00AA);
    #1;
    tests++; if (ad_a[15:0] !== 16'h00AA) begin fails++; $display("FAIL post_rst_byp got %h exp 00aa", ad_a[15:0]); end
    tests++; if (ad_n[15:0] !== 16'h0000) begin fails++; $display("FAIL post_rst_old got %h exp 0000", ad_n[15:0]); end
    step();
    idle();
    #1;
    tests++; if (ad_n[15:0] !== 16'h00AA) begin fails++; $display("FAIL post_rst_store got %h exp 00aa", ad_n[15:0]); end
  endtask

  task automatic test_distinct();
    idle();
    wr(0, 3'd1, 16'hBEEF);
    wr(1, 3'd2, 16'hCAFE);
    as_s = {3'd0, 3'd2};
    #1;
    tests++; if (wt_a !== 2'b00) begin fails++; $display("FAIL dist_wt got %b exp 00", wt_a); end
    tests++; if (ad_a[15:0] !== 16'hCAFE) begin fails++; $display("FAIL dist_byp got %h exp cafe", ad_a[15:0]); end
    tests++; if (ad_n[15:0] !== 16'h0000) begin fails++; $display("FAIL dist_nobyp got %h exp 0000", ad_n[15:0]); end
    step();
    idle();
    as_s = {3'd2, 3'd1};
    #1;
    tests++; if (ad_n !== 32'hCAFE_BEEF) begin fails++; $display("FAIL dist_store got %h exp cafebeef", ad_n); end
  endtask

  task automatic test_collision();
    logic [1:0]  exp_wt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [15:0] d0     [4] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    logic [15:0] d1     [4] = '{16'h2000, 16'h2001, 16'h2002, 16'h2003};
    logic [15:0] exp_bd [4] = '{16'h1000, 16'h2001, 16'h1002, 16'h2003};
    for (int i = 0; i < 4; i++) begin
      idle();
      wr(0, 3'd4, d0[i]);
      wr(1, 3'd4, d1[i]);
      bs_s[2:0] = 3'd4;
      #1;
      tests++; if (wt_a !== exp_wt[i]) begin fails++; $display("FAIL coll_wt[%0d] got %b exp %b", i, wt_a, exp_wt[i]); end
      tests++; if (bd_a[15:0] !== exp_bd[i]) begin fails++; $display("FAIL coll_byp[%0d] got %h exp %h", i, bd_a[15:0], exp_bd[i]); end
      step();
    end
    idle();
    as_s[2:0] = 3'd4;
    #1;
    tests++; if (ad_n[15:0] !== 16'h2003) begin fails++; $display("FAIL coll_final got %h exp 2003", ad_n[15:0]); end
  endtask

  task automatic test_scoreboard();
    idle();
    cs_s[2:0] = 3'd6;
    rsv[0]    = 1'b1;
    step();
    idle();
    tests++; if (busy_a !== 8'h40) begin fails++; $display("FAIL sb_set got %h exp 40", busy_a); end
    wr(1, 3'd6, 16'h6666);
    step();
    idle();
    tests++; if (busy_a !== 8'h00) begin fails++; $display("FAIL sb_clear got %h exp 00", busy_a); end
    cs_s[2:0] = 3'd6;
    rsv[0]    = 1'b1;
    step();
    idle();
    tests++; if (busy_a !== 8'h40) begin fails++; $display("FAIL sb_reset2 got %h exp 40", busy_a); end
    cs_s[2:0] = 3'd6;
    rsv[0]    = 1'b1;
    wr(1, 3'd6, 16'h7777);
    step();
    idle();
    cs_s = {3'd6, 3'd6};
    #1;
    tests++; if (busy_a !== 8'h40) begin fails++; $display("FAIL sb_set_wins got %h exp 40", busy_a); end
    tests++; if (cdo_n !== 32'h7777_7777) begin fails++; $display("FAIL sb_data got %h exp 77777777", cdo_n); end
  endtask

  task automatic test_zero_r0();
    idle();
    wr(0, 3'd0, 16'hFFFF);
    wr(1, 3'd0, 16'h1111);
    rsv[0] = 1'b1;
    as_s   = {3'd0, 3'd0};
    #1;
    tests++; if (wt_z !== 2'b00) begin fails++; $display("FAIL z_wt got %b exp 00", wt_z); end
    tests++; if (ad_z !== 32'h0) begin fails++; $display("FAIL z_ad got %h exp 0", ad_z); end
    tests++; if (wt_a !== 2'b10) begin fails++; $display("FAIL nz_wt got %b exp 10", wt_a); end
    step();
    idle();
    #1;
    tests++; if (busy_z[0] !== 1'b0) begin fails++; $display("FAIL z_busy got %b exp 0", busy_z[0]); end
    tests++; if (ad_z !== 32'h0) begin fails++; $display("FAIL z_ad_after got %h exp 0", ad_z); end
    tests++; if (busy_a[0] !== 1'b1) begin fails++; $display("FAIL nz_busy got %b exp 1", busy_a[0]); end
    tests++; if (ad_n[15:0] !== 16'hFFFF) begin fails++; $display("FAIL nz_r0 got %h exp ffff", ad_n[15:0]); end
  endtask

  task automatic test_nobypass();
    idle();
    wr(0, 3'd7, 16'h5555);
    as_s[2:0] = 3'd7;
    #1;
    tests++; if (ad_n[15:0] !== 16'h0000) begin fails++; $display("FAIL nb_old got %h exp 0000", ad_n[15:0]); end
    tests++; if (ad_a[15:0] !== 16'h5555) begin fails++; $display("FAIL nb_byp got %h exp 5555", ad_a[15:0]); end
    step();
    idle();
    #1;
    tests++; if (ad_n[15:0] !== 16'h5555) begin fails++; $display("FAIL nb_new got %h exp 5555", ad_n[15:0]); end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_collision();
    test_scoreboard();
    test_zero_r0();
    test_nobypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MiniMicro datapath. It generalises the two-port, eight-entry, 16-bit file in width, depth and port count. It adds round-robin resolution of same-register write collisions, optional write-to-read bypass, a hardwired-zero r0 option and a per-register busy scoreboard for multi-cycle operations. It sits between decode/issue (read select and reserve) and the execution units (write-back).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NREGS, 8, number of registers; power of two, at least 2; AW = log2(NREGS) is a derived localparam
- NPORTS, 2, number of identical ports, 1..4
- BYPASS, 1, 1 = a read of a register being committed this cycle returns the winning write data
- ZERO_R0, 0, 1 = r0 reads 0, ignores writes, and is never busy

Ports (per-port buses are packed; port p occupies slice p):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- as  in  NPORTS*AW  read-A select
- bs  in  NPORTS*AW  read-B select
- cs  in  NPORTS*AW  write / read-C / reserve select
- cw  in  NPORTS  write request
- cd  in  NPORTS*DATA_W  write data
- rsv  in  NPORTS  reserve request: mark register cs busy
- ad  out  NPORTS*DATA_W  read-A data
- bd  out  NPORTS*DATA_W  read-B data
- cdo  out  NPORTS*DATA_W  read-C data
- wt  out  NPORTS  wait: this port's write loses arbitration this cycle
- busy  out  NREGS  scoreboard; bit r = register r has a reservation pending

## Operation
- Reads are combinational.
  - BYPASS=0: reads return stored contents.
  - BYPASS=1: a read whose select equals a register committing this cycle returns the committing data.
  - ZERO_R0=1: r0 reads 0.
- Write arbitration is computed each cycle over ports with cw=1 (all cw are ignored while rst=1).
  - Ports targeting distinct registers all commit.
  - Among ports targeting the same register, exactly one wins: the first in rotating order starting at pointer rr.
  - Every losing port gets wt=1. The winner and non-colliding ports get wt=0.
  - A port with cw=0 always has wt=0.
- rr is a register of width clog2(NPORTS), reset 0. On any cycle containing at least one collision, rr advances to (lowest-index winner of a collision)+1 mod NPORTS. Otherwise rr holds.
- A losing port must hold cw/cs/cd until wt drops; the file keeps no queue.
- Scoreboard:
  - busy[r] is set at the clock edge after rsv[p]=1 with cs[p]=r.
  - It is cleared at the edge where a write to r commits.
  - If set and clear hit the same register in the same cycle, set wins: a new reservation overrides the old write-back.
  - Writes are accepted whether or not the register is busy. busy is advisory for issue logic.
- ZERO_R0=1: writes to r0 commit nothing, produce wt=0, and never set or clear busy[0].

## Timing
- Write commit: rising clk edge. The stored value is visible on non-bypass reads in the following cycle.
- Bypass path adds zero-cycle latency. Read output equals write data in the same cycle.
- wt is combinational from cw/cs and rr in the same cycle.
- Reset values: all registers 0, busy=0, rr=0.
  - All read outputs therefore read 0 during reset.
  - wt=0 during reset.
- Reset asserted mid-sequence clears everything immediately; pending reservations are lost. The first edge after deassertion behaves as cycle 0 with rr=0.

## Structure
- Package regfile_pkg holds:
  - clog2 function
  - default DATA_W/NREGS/NPORTS constants
  - shared port-index type used by decode
- Sub-module rr_arbiter(NPORTS): inputs request vector and pointer; output one-hot grant. One instance per port-as-target-group is not required. The parent compares each port against lower-priority ports and instantiates one arbiter for pointer update.

## Test plan
- Reset check: assert rst mid-run after writing r3=0x1234 and reserving r5 -> all reads 0, busy=0, wt=0. After release, write r3=0x00AA -> reads 0x00AA next cycle.
- Distinct-register writes: NPORTS=2, port0 writes r1=0xBEEF and port1 writes r2=0xCAFE the same cycle -> wt=00, both stored. With BYPASS=1, ad0 selecting r2 shows 0xCAFE in that cycle.
- Collision fairness: both ports write r4 on four consecutive cycles with distinct data -> winners alternate 0,1,0,1. wt toggles 10,01,10,01 (port1,port0 bit order). r4 ends with port1's last data.
- Scoreboard: rsv0 on r6 -> busy[6]=1 next cycle. Port1 write to r6 -> busy[6]=0 after that edge. rsv and write to r6 in the same cycle -> busy[6] stays 1 and the data is stored.
- ZERO_R0=1: write r0=0xFFFF plus rsv on r0 -> ad reads 0, busy[0]=0, wt=0.
- BYPASS=0 regression: write r7=0x5555 while reading r7 -> old value that cycle, 0x5555 the next.
